// File: rtl/lt24_frame_reader.sv
// lt24_frame_reader
// Avalon-MM read master that walks a frame buffer in on-chip memory and
// streams RGB565 pixels to the LT24 display writer. Each 32-bit word holds
// two pixels, low half first. A small word FIFO decouples memory reads from
// display back-pressure.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   start             single-cycle frame request (ignored while busy)
//   busy              high from accepted start until done
//   done              one-cycle pulse after the last pixel is accepted
//   mem_address       word address presented with mem_chipselect
//   mem_chipselect    read strobe
//   mem_write         tied low
//   mem_byteenable    tied to all bytes
//   mem_clken         tied high
//   mem_readdata      read data, valid the cycle after the address
//   pix_data          RGB565 pixel
//   pix_valid         pixel available
//   pix_ready         sink accepts the pixel
//   pix_sof, pix_eof  first / last pixel of the frame
module lt24_frame_reader #(
  parameter int ADDR_W     = 16,
  parameter int BASE_WORD  = 0,
  parameter int NUM_WORDS  = 38400,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eof
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WC_W  = $clog2(NUM_WORDS + 1);
  localparam int PC_W  = $clog2(2 * NUM_WORDS + 1);

  localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [WC_W-1:0]   WORD_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]   WORD_ZERO = WC_W'(0);
  localparam logic [PC_W-1:0]   LAST_PIX  = PC_W'(2 * NUM_WORDS - 1);
  localparam logic [PC_W-1:0]   PIX_ONE   = PC_W'(1);
  localparam logic [PC_W-1:0]   PIX_ZERO  = PC_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE_WORD);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [WC_W-1:0]     word_cnt_r;
  logic [PC_W-1:0]     pix_cnt_r;
  logic                busy_r, done_r;
  logic                cs_r;
  logic                pend_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    fifo_cnt_r;
  logic                half_r;
  logic [15:0]         pix_data_r;
  logic                pix_valid_r, pix_sof_r, pix_eof_r;

  logic                accept_s, issue_s, finish_s;
  logic                xfer_s, load_s, pop_s, push_s, fifo_empty_s, credit_s;
  logic [1:0]          outstanding_s;
  logic [CNT_W:0]      in_flight_s;
  logic [31:0]         head_s;

  assign accept_s     = (state_r == ST_IDLE) && start;
  assign xfer_s       = pix_valid_r && pix_ready;
  assign fifo_empty_s = (fifo_cnt_r == CNT_ZERO);
  // The output register refills whenever it is empty or being drained.
  assign load_s       = !fifo_empty_s && (!pix_valid_r || pix_ready);
  // A word leaves the FIFO once its upper half moves into the output register.
  assign pop_s        = load_s && half_r;
  // Read data arrives one cycle after the strobe is presented.
  assign push_s       = pend_r;
  assign head_s       = fifo_mem_r[rd_ptr_r];

  // Reads still in flight (strobe presented, or data arriving now) reserve
  // FIFO space so that a response never finds the FIFO full.
  assign outstanding_s = {1'b0, cs_r} + {1'b0, pend_r};
  assign in_flight_s   = {1'b0, fifo_cnt_r} + {{(CNT_W - 1){1'b0}}, outstanding_s};
  assign credit_s      = (in_flight_s < DEPTH_C);

  // Next-state and read-issue decisions
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    finish_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (credit_s) begin
          issue_s = 1'b1;
          if (word_cnt_r == LAST_WORD) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          issue_s     = 1'b0;
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (xfer_s && pix_eof_r && fifo_empty_s) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          finish_s    = 1'b0;
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Frame control, word counter and registered memory strobe/address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      word_cnt_r <= WORD_ZERO;
      cs_r       <= 1'b0;
      pend_r     <= 1'b0;
      addr_r     <= BASE_C;
    end else begin
      done_r <= finish_s;
      cs_r   <= issue_s;
      pend_r <= cs_r;
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end
      if (accept_s) begin
        word_cnt_r <= WORD_ZERO;
      end else if (issue_s) begin
        word_cnt_r <= word_cnt_r + WORD_ONE;
      end
      if (issue_s) begin
        // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
        addr_r <= BASE_C + ADDR_W'(word_cnt_r);
      end
    end
  end

  // FIFO storage; contents are discarded on reset via the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= mem_readdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Registered pixel output with half-word unpacking and frame flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_data_r  <= 16'h0000;
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eof_r   <= 1'b0;
      pix_cnt_r   <= PIX_ZERO;
      half_r      <= 1'b0;
    end else if (accept_s) begin
      pix_cnt_r <= PIX_ZERO;
      half_r    <= 1'b0;
    end else if (load_s) begin
      pix_data_r  <= half_r ? head_s[31:16] : head_s[15:0];
      pix_valid_r <= 1'b1;
      pix_sof_r   <= (pix_cnt_r == PIX_ZERO);
      pix_eof_r   <= (pix_cnt_r == LAST_PIX);
      pix_cnt_r   <= pix_cnt_r + PIX_ONE;
      half_r      <= ~half_r;
    end else if (xfer_s) begin
      pix_valid_r <= 1'b0;
      pix_sof_r   <= 1'b0;
      pix_eof_r   <= 1'b0;
    end
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign mem_address    = addr_r;
  assign mem_chipselect = cs_r;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign pix_data       = pix_data_r;
  assign pix_valid      = pix_valid_r;
  assign pix_sof        = pix_sof_r;
  assign pix_eof        = pix_eof_r;

endmodule

// File: tb/tb_lt24_frame_reader.sv
// Testbench for lt24_frame_reader. Two instances share one memory model:
//   u0: BASE_WORD=0x0100, NUM_WORDS=4,  FIFO_DEPTH=4
//   u1: BASE_WORD=0xFFFE, NUM_WORDS=16, FIFO_DEPTH=4 (address wrap, credit limit)
// Starting a frame pushes the expected pixel and address sequences into
// queues; per-instance monitors pop and compare whenever the DUT presents.
module tb_lt24_frame_reader;

  localparam int NI = 2;

  typedef struct packed {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } pix_t;

  logic        clk;
  logic        rst;
  logic        start  [NI];
  logic        busy   [NI];
  logic        done   [NI];
  logic [15:0] addr   [NI];
  logic        cs     [NI];
  logic        wr     [NI];
  logic [3:0]  be     [NI];
  logic        clken  [NI];
  logic [31:0] rdata  [NI];
  logic [15:0] pdata  [NI];
  logic        pvalid [NI];
  logic        pready [NI];
  logic        psof   [NI];
  logic        peof   [NI];

  logic [31:0] mem [0:65535];
  pix_t        exp_q  [NI][$];
  logic [15:0] addr_q [NI][$];
  int          mode   [NI];   // 0 ready high, 1 ready low, 2 toggle, 3 random
  int          errors;
  int          checks;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nw_of(input int g);
    return (g == 0) ? 4 : 16;
  endfunction

  function automatic logic [15:0] base_of(input int g);
    return (g == 0) ? 16'h0100 : 16'hFFFE;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    int   reads_cnt = 0;
    int   done_cnt  = 0;
    int   xfer_cnt  = 0;
    logic stalled   = 1'b0;
    logic fin       = 1'b0;

    lt24_frame_reader #(
      .ADDR_W     (16),
      .BASE_WORD  ((g == 0) ? 256 : 65534),
      .NUM_WORDS  ((g == 0) ? 4 : 16),
      .FIFO_DEPTH (4)
    ) u_dut (
      .clk            (clk),
      .reset          (rst),
      .start          (start[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .mem_address    (addr[g]),
      .mem_chipselect (cs[g]),
      .mem_write      (wr[g]),
      .mem_byteenable (be[g]),
      .mem_clken      (clken[g]),
      .mem_readdata   (rdata[g]),
      .pix_data       (pdata[g]),
      .pix_valid      (pvalid[g]),
      .pix_ready      (pready[g]),
      .pix_sof        (psof[g]),
      .pix_eof        (peof[g])
    );

    // memory slave: data one cycle after the address
    always @(posedge clk) rdata[g] <= mem[addr[g]];

    always @(negedge clk) begin : mon
      pix_t e;
      logic nf;
      nf = 1'b0;
      if (rst) begin
        stalled = 1'b0;
        fin     = 1'b0;
      end else begin
        check($sformatf("u%0d done_pulse", g), done[g], fin);
        if (done[g]) done_cnt++;
        if (fin) check($sformatf("u%0d busy_at_done", g), busy[g], 1'b0);
        if (stalled) check($sformatf("u%0d valid_held", g), pvalid[g], 1'b1);
        if (pvalid[g]) begin
          if (exp_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d unexpected_pixel: got %0h expected none", g, pdata[g]);
          end else begin
            e = exp_q[g][0];
            check($sformatf("u%0d pix_data", g), pdata[g], e.d);
            check($sformatf("u%0d pix_sof", g), psof[g], e.sof);
            check($sformatf("u%0d pix_eof", g), peof[g], e.eof);
            if (pready[g]) begin
              void'(exp_q[g].pop_front());
              nf = e.eof;
              xfer_cnt++;
            end
          end
        end
        if (cs[g]) begin
          reads_cnt++;
          if (addr_q[g].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d unexpected_read: got %0h expected none", g, addr[g]);
          end else begin
            check($sformatf("u%0d mem_address", g), addr[g], addr_q[g].pop_front());
          end
        end
        stalled = pvalid[g] && !pready[g];
        fin     = nf;
      end
    end
  end

  function automatic int reads_of(input int g);
    if (g == 0) return g_inst[0].reads_cnt;
    else        return g_inst[1].reads_cnt;
  endfunction

  function automatic int dones_of(input int g);
    if (g == 0) return g_inst[0].done_cnt;
    else        return g_inst[1].done_cnt;
  endfunction

  function automatic int xfers_of(input int g);
    if (g == 0) return g_inst[0].xfer_cnt;
    else        return g_inst[1].xfer_cnt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) begin
      case (mode[g])
        0:       pready[g] = 1'b1;
        1:       pready[g] = 1'b0;
        2:       pready[g] = ~pready[g];
        3:       pready[g] = 1'($urandom_range(0, 1));
        default: pready[g] = 1'b1;
      endcase
    end
  endtask

  // Reference: word-major, low half then high half; sof on pixel 0, eof on last.
  task automatic start_frame(input int g);
    logic [15:0] a;
    logic [31:0] w;
    pix_t        p;
    for (int i = 0; i < nw_of(g); i++) begin
      a = base_of(g) + 16'(i);
      w = mem[a];
      addr_q[g].push_back(a);
      p.d = w[15:0];  p.sof = (i == 0); p.eof = 1'b0;
      exp_q[g].push_back(p);
      p.d = w[31:16]; p.sof = 1'b0;     p.eof = (i == nw_of(g) - 1);
      exp_q[g].push_back(p);
    end
    start[g] = 1'b1;
    tick();
    start[g] = 1'b0;
    check($sformatf("u%0d busy_after_start", g), busy[g], 1'b1);
  endtask

  task automatic wait_idle(input int g, output int span);
    int   t;
    logic seen;
    t    = 0;
    seen = 1'b0;
    span = 0;
    while (busy[g] && t < 3000) begin
      if (pvalid[g]) seen = 1'b1;
      if (seen) span++;
      tick();
      t++;
    end
    check($sformatf("u%0d frame_timeout", g), busy[g], 1'b0);
    tick();
    tick();
    check($sformatf("u%0d pixels_left", g), exp_q[g].size(), 0);
    check($sformatf("u%0d reads_left", g), addr_q[g].size(), 0);
  endtask

  task automatic check_reset_state(input int g);
    check($sformatf("u%0d rst busy", g), busy[g], 1'b0);
    check($sformatf("u%0d rst done", g), done[g], 1'b0);
    check($sformatf("u%0d rst chipselect", g), cs[g], 1'b0);
    check($sformatf("u%0d rst address", g), addr[g], base_of(g));
    check($sformatf("u%0d rst pix_valid", g), pvalid[g], 1'b0);
    check($sformatf("u%0d rst pix_sof", g), psof[g], 1'b0);
    check($sformatf("u%0d rst pix_eof", g), peof[g], 1'b0);
    check($sformatf("u%0d rst pix_data", g), pdata[g], 16'h0000);
    check($sformatf("u%0d mem_write", g), wr[g], 1'b0);
    check($sformatf("u%0d mem_byteenable", g), be[g], 4'hF);
    check($sformatf("u%0d mem_clken", g), clken[g], 1'b1);
  endtask

  task automatic fill_random(input int g);
    for (int i = 0; i < nw_of(g); i++) mem[base_of(g) + 16'(i)] = $urandom;
  endtask

  initial begin
    int span;
    int r0, d0, x0, t;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    for (int g = 0; g < NI; g++) begin
      start[g]  = 1'b0;
      pready[g] = 1'b0;
      mode[g]   = 0;
    end
    mem[16'h0100] = 32'h2222_1111;
    mem[16'h0101] = 32'h4444_3333;
    mem[16'h0102] = 32'h6666_5555;
    mem[16'h0103] = 32'h8888_7777;
    fill_random(1);

    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < NI; g++) check_reset_state(g);
    rst = 1'b0;
    tick();

    // basic frame, ready held high: in-order pixels, zero-bubble stream
    d0 = dones_of(0); x0 = xfers_of(0);
    start_frame(0);
    wait_idle(0, span);
    check("u0 done_count", dones_of(0) - d0, 1);
    check("u0 pixel_count", xfers_of(0) - x0, 8);
    check("u0 stream_span", span, 8);

    d0 = dones_of(1);
    start_frame(1);
    wait_idle(1, span);
    check("u1 done_count", dones_of(1) - d0, 1);
    check("u1 stream_span", span, 32);

    // sink stalled: reads stop once the FIFO credit is used up
    for (int g = 0; g < NI; g++) begin
      mode[g] = 1;
      tick();
      r0 = reads_of(g);
      start_frame(g);
      repeat (20) tick();
      check($sformatf("u%0d stalled_reads", g), reads_of(g) - r0, 4);
      check($sformatf("u%0d stalled_cs", g), cs[g], 1'b0);
      check($sformatf("u%0d stalled_valid", g), pvalid[g], 1'b1);
      check($sformatf("u%0d stalled_data", g), pdata[g], mem[base_of(g)][15:0]);
      mode[g] = 0;
      wait_idle(g, span);
    end

    // alternating ready
    mode[0] = 2;
    x0 = xfers_of(0);
    start_frame(0);
    wait_idle(0, span);
    check("u0 toggle_pixels", xfers_of(0) - x0, 8);

    // second start while busy is ignored
    mode[0] = 1;
    d0 = dones_of(0); x0 = xfers_of(0);
    start_frame(0);
    tick();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    mode[0] = 0;
    wait_idle(0, span);
    check("u0 restart_done_count", dones_of(0) - d0, 1);
    check("u0 restart_pixels", xfers_of(0) - x0, 8);

    // randomized back-pressure and data
    for (int f = 0; f < 8; f++) begin
      int g;
      g = f % 2;
      mode[g] = 3;
      if (g == 1) fill_random(1);
      d0 = dones_of(g);
      start_frame(g);
      wait_idle(g, span);
      check($sformatf("u%0d rand_done_count", g), dones_of(g) - d0, 1);
      mode[g] = 0;
    end

    // reset in the middle of a frame, then a fresh frame from the base
    mode[0] = 0;
    x0 = xfers_of(0);
    start_frame(0);
    t = 0;
    while ((xfers_of(0) - x0) < 3 && t < 200) begin
      tick();
      t++;
    end
    check("u0 midframe_progress", ((xfers_of(0) - x0) >= 3) ? 1 : 0, 1);
    rst = 1'b1;
    exp_q[0].delete();
    addr_q[0].delete();
    #2;
    check_reset_state(0);
    tick();
    rst = 1'b0;
    tick();
    d0 = dones_of(0);
    start_frame(0);
    wait_idle(0, span);
    check("u0 post_reset_done_count", dones_of(0) - d0, 1);

    // ready high while idle: nothing is produced
    mode[0] = 0;
    mode[1] = 0;
    repeat (10) tick();
    check("u0 idle_valid", pvalid[0], 1'b0);
    check("u1 idle_valid", pvalid[1], 1'b0);
    check("u0 idle_busy", busy[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt24_frame_reader.md
Name: lt24_frame_reader

Overview:
- Avalon-MM read master that scans a frame buffer held in the on-chip memory and streams RGB565 pixels to the LT24 display writer.
- Each 32-bit memory word holds two pixels: low half first, then high half.
- Sits between the on-chip memory slave port and the LT24 pixel sink.
- Decouples memory read timing from display back-pressure with a small word FIFO.

Parameters:
- ADDR_W, 16, word-address width of the memory port.
- BASE_WORD, 0, word address of the first frame word.
- NUM_WORDS, 38400, words per frame (240x320 pixels / 2).
- FIFO_DEPTH, 8, word FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame request.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel is accepted.
- mem_address  out  ADDR_W  word address.
- mem_chipselect  out  1  read strobe.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  32  read data, valid the cycle after the address is presented.
- pix_data  out  16  RGB565 pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts the pixel.
- pix_sof  out  1  qualifies the first pixel of the frame.
- pix_eof  out  1  qualifies the last pixel of the frame.

Behaviour:
- Reset values:
  - busy=0, done=0, mem_chipselect=0, mem_address=BASE_WORD, pix_valid=0, pix_sof=0, pix_eof=0, pix_data=0.
  - FIFO empty, outstanding=0, FSM=IDLE.
- FSM transitions:
  - IDLE -> RUN on start; word counter cleared, busy=1 the next cycle.
  - RUN -> DRAIN the cycle after the read for word NUM_WORDS-1 is issued.
  - DRAIN -> IDLE when the FIFO is empty and the final pixel handshake completes; done=1 for exactly that one cycle.
- start while busy is ignored.
- Read issue:
  - In RUN, assert mem_chipselect with mem_address=BASE_WORD+count only when fifo_count+outstanding < FIFO_DEPTH.
  - Each issue increments count; address wraps modulo 2^ADDR_W.
  - The read response is captured into the FIFO on the next cycle unconditionally; no read is ever dropped.
  - Reads may issue back-to-back every cycle while credit allows.
- Handshake:
  - A pixel transfers when pix_valid && pix_ready.
  - While pix_valid && !pix_ready, pix_data, pix_sof and pix_eof hold stable.
  - pix_valid never drops without a transfer.
- Unpacking:
  - Head word emits [15:0] first, then [31:16].
  - The word is popped on the second transfer.
  - Output is registered, so pixel latency is 1 cycle after data reaches the FIFO head.
  - Zero-bubble: with pix_ready held high and the FIFO non-empty, one pixel transfers per cycle.
- Flags:
  - pix_sof=1 only on pixel 0.
  - pix_eof=1 only on pixel 2*NUM_WORDS-1.
- Simultaneous FIFO push and pop in the same cycle: count unchanged. Full with a pending response cannot occur because of credit gating.
- Asynchronous reset mid-frame:
  - Immediately returns to reset values and discards FIFO contents and outstanding reads.
  - The next start reads from BASE_WORD.
- pix_ready asserted in IDLE has no effect.

Test Plan:
- Reset, then start, with NUM_WORDS=4, BASE_WORD=0x0100, mem[0x100..0x103]=0x2222_1111, 0x4444_3333, 0x6666_5555, 0x8888_7777, and pix_ready=1 -> pixels 0x1111, 0x2222, … 0x8888 in order. sof on 0x1111, eof on 0x8888, done pulses once, busy drops the same cycle.
- pix_ready=0 for 20 cycles after start, FIFO_DEPTH=4 -> exactly 4 reads issued, chipselect then low. pix_data=0x1111 held stable with pix_valid=1. No words lost after ready rises.
- pix_ready toggled 1,0,1,0 -> each pixel appears exactly once, values unchanged across stall cycles.
- Second start pulsed while busy -> ignored: single frame, single done pulse, 8 pixels total.
- Reset asserted mid-frame after 3 pixels, then start -> first pixel 0x1111 with sof, reads restart at 0x0100.
- BASE_WORD=0xFFFE, NUM_WORDS=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 are issued.
